led_sweep_routine: RTL and testbench

//  Parametrised LED light routine: sweeps a lit bar across an LED_W-wide LED bank in

---
 rtl/led_sweep_routine.sv | 187 ++++++++++++++++++
 tb/tb_led_sweep_routine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_routine.sv
// LED sweep routine: a BAR_W-wide lit bar bounces or rotates across the LED bank,
// one position per Enable step, with a cascaded step counter on seven-segment digits.
module led_sweep_routine #(
  parameter int LED_W      = 18,
  parameter int BAR_W      = 4,
  parameter int HEX_DIGITS = 4,
  parameter int HEX_MOD    = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Mode,
  output logic [LED_W-1:0]        LedOut,
  output logic [7*HEX_DIGITS-1:0] HexSeg,
  output logic                    Done
);

  localparam int POS_W  = $clog2(LED_W + 1);
  localparam int MAXPOS = LED_W - BAR_W;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic [POS_W-1:0] POS_ZERO = POS_W'(0);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(MAXPOS);
  localparam logic [POS_W-1:0] POS_END  = POS_W'(LED_W);

  localparam logic [LED_W-1:0] BAR_BASE = {{(LED_W-BAR_W){1'b0}}, {BAR_W{1'b1}}};
  localparam logic [3:0]       DIG_MAX  = 4'(HEX_MOD - 1);

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [1:0]              state_r, state_s;
  logic [POS_W-1:0]        pos_r, pos_s;
  logic [LED_W-1:0]        led_r, led_s;
  logic                    mode_r, mode_s;
  logic                    done_r, done_s;
  logic [4*HEX_DIGITS-1:0] count_r, count_s;
  logic [7*HEX_DIGITS-1:0] hex_r, hex_s;
  logic                    carry_s;

  // Sweep FSM next state; a Mode change mid-sweep restarts the bar like LOAD
  always_comb begin
    state_s = state_r;
    pos_s   = pos_r;
    led_s   = led_r;
    mode_s  = mode_r;
    done_s  = 1'b0;
    if (Enable) begin
      case (state_r)
        ST_LOAD: begin
          led_s   = BAR_BASE;
          pos_s   = POS_ZERO;
          mode_s  = Mode;
          state_s = ST_UP;
        end
        ST_UP: begin
          if (Mode != mode_r) begin
            led_s   = BAR_BASE;
            pos_s   = POS_ZERO;
            mode_s  = Mode;
            state_s = ST_UP;
          end else if (!mode_r) begin
            pos_s = pos_r + POS_ONE;
            led_s = {led_r[LED_W-2:0], 1'b0};
            if (pos_s == POS_MAX) begin
              state_s = ST_DOWN;
            end else begin
              state_s = ST_UP;
            end
          end else begin
            led_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
            if (pos_r + POS_ONE == POS_END) begin
              pos_s  = POS_ZERO;
              done_s = 1'b1;
            end else begin
              pos_s  = pos_r + POS_ONE;
            end
            state_s = ST_UP;
          end
        end
        ST_DOWN: begin
          if (Mode != mode_r) begin
            led_s   = BAR_BASE;
            pos_s   = POS_ZERO;
            mode_s  = Mode;
            state_s = ST_UP;
          end else begin
            pos_s = pos_r - POS_ONE;
            led_s = {1'b0, led_r[LED_W-1:1]};
            if (pos_s == POS_ZERO) begin
              done_s  = 1'b1;
              state_s = ST_UP;
            end else begin
              state_s = ST_DOWN;
            end
          end
        end
        default: begin
          led_s   = {LED_W{1'b0}};
          pos_s   = POS_ZERO;
          state_s = ST_LOAD;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Cascaded step counter: each digit wraps at HEX_MOD and carries into the next
  always_comb begin
    count_s = count_r;
    carry_s = Enable;
    for (int k = 0; k < HEX_DIGITS; k++) begin
      if (carry_s) begin
        if (count_r[4*k +: 4] == DIG_MAX) begin
          count_s[4*k +: 4] = 4'd0;
          carry_s           = 1'b1;
        end else begin
          count_s[4*k +: 4] = count_r[4*k +: 4] + 4'd1;
          carry_s           = 1'b0;
        end
      end else begin
        carry_s = 1'b0;
      end
    end
  end

  // Display is decoded from the next count so it updates on the same edge as the count
  always_comb begin
    hex_s = {(7*HEX_DIGITS){1'b1}};
    for (int k = 0; k < HEX_DIGITS; k++) begin
      hex_s[7*k +: 7] = seg_decode(count_s[4*k +: 4]);
    end
  end

  // State and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_LOAD;
      pos_r   <= POS_ZERO;
      led_r   <= {LED_W{1'b0}};
      mode_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= {(4*HEX_DIGITS){1'b0}};
      hex_r   <= {HEX_DIGITS{7'b1000000}};
    end else begin
      state_r <= state_s;
      pos_r   <= pos_s;
      led_r   <= led_s;
      mode_r  <= mode_s;
      done_r  <= done_s;
      count_r <= count_s;
      hex_r   <= hex_s;
    end
  end

  assign LedOut = led_r;
  assign HexSeg = hex_r;
  assign Done   = done_r;

endmodule

// File: tb/tb_led_sweep_routine.sv
// Bench for led_sweep_routine: constant vector table, directed corner sequences and
// randomized steps against a period/phase reference model; a second decimal instance.
module tb_led_sweep_routine;

  localparam int LED_W  = 18;
  localparam int BAR_W  = 4;
  localparam int MAXPOS = LED_W - BAR_W;
  localparam logic [17:0] BASE = 18'h0000F;

  logic        Clock, Reset, Enable, Mode;
  logic [17:0] led16, led10;
  logic [27:0] hex16;
  logic [13:0] hex10;
  logic        done16, done10;

  led_sweep_routine #(.LED_W(18), .BAR_W(4), .HEX_DIGITS(4), .HEX_MOD(16)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode),
    .LedOut(led16), .HexSeg(hex16), .Done(done16));

  led_sweep_routine #(.LED_W(18), .BAR_W(4), .HEX_DIGITS(2), .HEX_MOD(10)) dut10 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Mode(Mode),
    .LedOut(led10), .HexSeg(hex10), .Done(done10));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: steps since last LOAD, total enabled steps, latched mode
  bit m_loaded;
  bit m_mode;
  bit m_done;
  int m_k;
  int m_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mdl_led();
    int pos;
    int ph;
    logic [35:0] w;
    if (!m_loaded) return 18'h0;
    if (!m_mode) begin
      ph  = m_k % (2 * MAXPOS);
      pos = (ph <= MAXPOS) ? ph : (2 * MAXPOS - ph);
      return BASE << pos;
    end
    pos = m_k % LED_W;
    w   = {18'h0, BASE} << pos;
    return w[17:0] | w[35:18];
  endfunction

  function automatic logic [55:0] mdl_hex(input int n, input int base, input int digits);
    logic [55:0] r;
    int d;
    r = 56'h0;
    d = n;
    for (int i = 0; i < digits; i++) begin
      r[7*i +: 7] = seg_tab[d % base];
      d = d / base;
    end
    return r;
  endfunction

  task automatic check_model();
    logic [55:0] h16;
    logic [55:0] h10;
    h16 = mdl_hex(m_n, 16, 4);
    h10 = mdl_hex(m_n, 10, 2);
    chk("led",   64'(led16),  64'(mdl_led()));
    chk("done",  64'(done16), 64'(m_done));
    chk("hex16", 64'(hex16),  64'(h16[27:0]));
    chk("led10", 64'(led10),  64'(mdl_led()));
    chk("done10", 64'(done10), 64'(m_done));
    chk("hex10", 64'(hex10),  64'(h10[13:0]));
  endtask

  task automatic step(input logic en, input logic md);
    @(negedge Clock);
    Enable = en;
    Mode   = md;
    @(posedge Clock);
    #1;
    if (en) begin
      if (!m_loaded || md != m_mode) begin
        m_loaded = 1'b1;
        m_mode   = md;
        m_k      = 0;
        m_done   = 1'b0;
      end else begin
        m_k++;
        m_done = m_mode ? (m_k % LED_W == 0) : (m_k % (2 * MAXPOS) == 0);
      end
      m_n++;
    end else begin
      m_done = 1'b0;
    end
    check_model();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Enable = 1'b0;
    Reset  = 1'b1;
    #1;
    m_loaded = 1'b0; m_mode = 1'b0; m_done = 1'b0; m_k = 0; m_n = 0;
    chk("rst_led", 64'(led16), 64'h0);
    chk("rst_done", 64'(done16), 64'h0);
    chk("rst_hex16", 64'(hex16), 64'({4{7'h40}}));
    chk("rst_hex10", 64'(hex10), 64'({2{7'h40}}));
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        md;
    logic [17:0] led;
    logic        done;
    int          cnt;
  } vec_t;

  vec_t vecs [8];
  logic prev_done;
  logic md_r;

  initial begin
    Reset = 1'b0; Enable = 1'b0; Mode = 1'b0;
    m_loaded = 1'b0; m_mode = 1'b0; m_done = 1'b0; m_k = 0; m_n = 0;

    vecs[0] = '{1'b1, 1'b0, 18'h0000F, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b0, 18'h0000F, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b0, 18'h0001E, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b0, 18'h0003C, 1'b0, 3};
    vecs[4] = '{1'b0, 1'b1, 18'h0003C, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b1, 18'h0000F, 1'b0, 4};
    vecs[6] = '{1'b1, 1'b1, 18'h0001E, 1'b0, 5};
    vecs[7] = '{1'b1, 1'b0, 18'h0000F, 1'b0, 6};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].en, vecs[i].md);
      chk("vec_led", 64'(led16), 64'(vecs[i].led));
      chk("vec_done", 64'(done16), 64'(vecs[i].done));
      chk("vec_dig0", 64'(hex16[6:0]), 64'(seg_tab[vecs[i].cnt]));
      chk("vec_dig1", 64'(hex16[13:7]), 64'(7'h40));
    end

    // Bounce: peak at step 15, Done at steps 29 and 57 only
    do_reset();
    for (int s = 1; s <= 57; s++) begin
      step(1'b1, 1'b0);
      if (s == 15) chk("bounce_peak", 64'(led16), 64'h3C000);
      chk("bounce_done", 64'(done16), 64'((s == 29) || (s == 57)));
      if (s == 29) chk("bounce_home", 64'(led16), 64'h0000F);
    end

    // Rotate: wrap across bit 17/0, Done at step 19
    do_reset();
    for (int s = 1; s <= 19; s++) begin
      step(1'b1, 1'b1);
      if (s == 16) chk("rot_wrap", 64'(led16), 64'h38001);
      chk("rot_done", 64'(done16), 64'(s == 19));
    end
    chk("rot_home", 64'(led16), 64'h0000F);

    // Enable toggled: Done never high in two consecutive cycles
    do_reset();
    prev_done = 1'b0;
    for (int s = 0; s < 120; s++) begin
      step(s[0] == 1'b0, 1'b0);
      chk("done_consec", 64'(prev_done & done16), 64'h0);
      prev_done = done16;
    end

    // Decimal counter: 10 -> "10", 100 -> "00"
    do_reset();
    for (int s = 1; s <= 100; s++) begin
      step(1'b1, 1'b0);
      if (s == 10) chk("dec_carry", 64'(hex10), 64'({7'h79, 7'h40}));
      if (s == 99) chk("dec_99", 64'(hex10), 64'({7'h10, 7'h10}));
    end
    chk("dec_wrap", 64'(hex10), 64'({7'h40, 7'h40}));

    // Mode flip at pos 7, then async reset mid-cycle
    do_reset();
    for (int s = 0; s < 8; s++) step(1'b1, 1'b0);
    chk("pos7", 64'(led16), 64'h00780);
    step(1'b1, 1'b1);
    chk("flip_led", 64'(led16), 64'h0000F);
    chk("flip_done", 64'(done16), 64'h0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_led", 64'(led16), 64'h0);
    chk("async_hex", 64'(hex16), 64'({4{7'h40}}));
    chk("async_done", 64'(done16), 64'h0);
    m_loaded = 1'b0; m_mode = 1'b0; m_done = 1'b0; m_k = 0; m_n = 0;
    Enable = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    step(1'b1, 1'b1);
    chk("post_rst_load", 64'(led16), 64'h0000F);

    // Randomized steps against the model
    md_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 24) == 0) md_r = ~md_r;
        step($urandom_range(0, 3) != 0, md_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
